cla_pipe_adder: RTL and testbench

- Parametrised, 3-stage pipelined carry-lookahead adder/subtractor with a two-level lookahead tree.
- Built from 4-bit lookahead groups that produce group propagate/generate signals.
- Valid/ready handshakes on input and output give full throughput with backpressure.
- Used as the arithmetic datapath unit in the lecture CPU and accumulator designs, replacing ripple/flat CLA adders.

---
 rtl/cla_pkg.sv | 36 +++
 rtl/cla_lookahead4.sv | 24 ++
 rtl/cla_pipe_adder.sv | 175 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, stage payload type and 4-bit lookahead carry function
// for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned GRP_W   = 4;
    localparam int unsigned MAX_W   = 64;
    localparam int unsigned MAX_GRP = MAX_W / GRP_W;

    // Payload sized for the widest legal adder; narrower instances leave upper bits at zero
    typedef struct packed {
        logic               valid;
        logic [MAX_W-1:0]   p;
        logic [MAX_W-1:0]   g;
        logic [MAX_GRP-1:0] cg;
        logic               cin;
        logic               a_msb;
        logic               bx_msb;
    } stage_t;

    // Returns carries out of bits 0..3 of a group: {c4, c3, c2, c1}
    function automatic logic [GRP_W-1:0] la4_carries(
        input logic [GRP_W-1:0] g,
        input logic [GRP_W-1:0] p,
        input logic             cin
    );
        logic [GRP_W-1:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// Combinational 4-bit carry-lookahead group: in-group carries plus
// group propagate/generate for the second lookahead level.
module cla_lookahead4
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] g_i,
    input  logic [GRP_W-1:0] p_i,
    input  logic             ci_i,
    output logic [3:1]       c_o,
    output logic             co_o,
    output logic             pg_o,
    output logic             gg_o
);

    logic [GRP_W-1:0] carries;

    assign carries = la4_carries(g_i, p_i, ci_i);
    assign c_o     = carries[2:0];
    assign co_o    = carries[3];
    assign pg_o    = &p_i;
    assign gg_o    = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                   | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined two-level carry-lookahead adder/subtractor with
// valid/ready handshakes and collapsing bubbles.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NGRP = WIDTH / GRP_W;

    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // A stage may load when it is empty or its contents move on this edge
    logic en1, en2, en3;
    assign en3      = !out_valid_q || out_ready;
    assign en2      = !s2_q.valid || en3;
    assign en1      = !s1_q.valid || en2;
    assign in_ready = en1;

    logic [WIDTH-1:0] bx;
    logic             cin_eff;
    assign bx      = sub ? ~b : b;
    assign cin_eff = sub ^ ci;

    always_comb begin
        s1_d = s1_q;
        if (en1) begin
            s1_d.valid = in_valid;
            if (in_valid) begin
                s1_d.p            = '0;
                s1_d.g            = '0;
                s1_d.cg           = '0;
                s1_d.p[WIDTH-1:0] = a ^ bx;
                s1_d.g[WIDTH-1:0] = a & bx;
                s1_d.cin          = cin_eff;
                s1_d.a_msb        = a[WIDTH-1];
                s1_d.bx_msb       = bx[WIDTH-1];
            end
        end
    end

    // Stage 2: group P/G, then second-level lookahead for each group carry-in
    logic [NGRP-1:0][2:0] c2_unused;
    logic [NGRP-1:0]      co2_unused;
    logic [NGRP-1:0]      pg2, gg2;
    logic [NGRP:0]        cg2;

    for (genvar k = 0; k < NGRP; k++) begin : g_s2
        cla_lookahead4 u_la (
            .g_i  (s1_q.g[GRP_W*k +: GRP_W]),
            .p_i  (s1_q.p[GRP_W*k +: GRP_W]),
            .ci_i (1'b0),
            .c_o  (c2_unused[k]),
            .co_o (co2_unused[k]),
            .pg_o (pg2[k]),
            .gg_o (gg2[k])
        );
    end

    always_comb begin
        cg2    = '0;
        cg2[0] = s1_q.cin;
        for (int unsigned k = 0; k < NGRP; k++) begin
            cg2[k+1] = gg2[k] | (pg2[k] & cg2[k]);
        end
    end

    always_comb begin
        s2_d = s2_q;
        if (en2) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d                = s1_q;
                s2_d.cg             = '0;
                s2_d.cg[NGRP-1:0]   = cg2[NGRP-1:0];
            end
        end
    end

    // Stage 3: rebuild bit carries inside each group from the stored group carry-in
    logic [NGRP-1:0][2:0] c3;
    logic [NGRP-1:0]      co3;
    logic [NGRP-1:0]      pg3_unused, gg3_unused;
    logic [WIDTH-1:0]     carry3;

    for (genvar k = 0; k < NGRP; k++) begin : g_s3
        cla_lookahead4 u_la (
            .g_i  (s2_q.g[GRP_W*k +: GRP_W]),
            .p_i  (s2_q.p[GRP_W*k +: GRP_W]),
            .ci_i (s2_q.cg[k]),
            .c_o  (c3[k]),
            .co_o (co3[k]),
            .pg_o (pg3_unused[k]),
            .gg_o (gg3_unused[k])
        );
        assign carry3[GRP_W*k]        = s2_q.cg[k];
        assign carry3[GRP_W*k+1 +: 3] = c3[k];
    end

    logic [WIDTH-1:0] sum_n;
    logic             co_n;
    assign sum_n = s2_q.p[WIDTH-1:0] ^ carry3;
    assign co_n  = co3[NGRP-1];

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (en3) begin
            out_valid_d = s2_q.valid;
            if (s2_q.valid) begin
                sum_d  = sum_n;
                co_d   = co_n;
                ovf_d  = carry3[WIDTH-1] ^ co_n;
                zero_d = (sum_n == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Payload fields kept for observability or unused at this width
    logic unused_bits;
    assign unused_bits = ^{s1_q, s2_q, cg2, c2_unused, co2_unused,
                           pg3_unused, gg3_unused, co3};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver pushes model results on accept,
// monitor checks outputs, handshake capacity, latency and stall stability.
module tb_cla_pipe_adder;

    localparam int unsigned W = 16;
    localparam longint ULIM = longint'(1) << W;
    localparam longint SMAX = (longint'(1) << (W-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W-1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         co, ovf, zero;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
    } beat_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        res_t r;
        time  t;
    } exp_t;

    beat_t stim_q[$];
    exp_t  exp_q[$];

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;
    int idle_pct = 0;
    int cyc = 0;
    bit do_rst = 1'b1;
    bit post_rst = 1'b0;
    bit holding = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operand values
    function automatic res_t model(input beat_t t);
        longint ua, ub, c, sa, sb, ur, sr;
        res_t   r;
        ua = longint'(t.a);
        ub = longint'(t.b);
        c  = longint'(t.ci);
        sa = longint'($signed(t.a));
        sb = longint'($signed(t.b));
        if (!t.sub) begin
            ur   = ua + ub + c;
            sr   = sa + sb + c;
            r.co = (ur >= ULIM);
        end else begin
            ur   = ua - ub - c;
            sr   = sa - sb - c;
            r.co = (ua >= ub + c);
        end
        r.sum  = W'(ur);
        r.ovf  = (sr > SMAX) || (sr < SMIN);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb,
                        input logic pci, input logic psub);
        beat_t t;
        t.a = pa; t.b = pb; t.ci = pci; t.sub = psub;
        stim_q.push_back(t);
    endtask

    // Driver: presents beats, holds them until accepted, records expectations
    always begin
        beat_t cur;
        exp_t  e;
        @(negedge clk);
        #1;
        if (do_rst) begin
            rst      = 1'b1;
            in_valid = 1'b0;
            holding  = 1'b0;
        end else begin
            rst = 1'b0;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 99) < 60);
                2:       out_ready = !(cyc >= 4 && cyc <= 8);
                default: out_ready = 1'b0;
            endcase
            if (!holding) begin
                if (stim_q.size() > 0 && int'($urandom_range(0, 99)) >= idle_pct) begin
                    cur      = stim_q[0];
                    in_valid = 1'b1;
                    a        = cur.a;
                    b        = cur.b;
                    ci       = cur.ci;
                    sub      = cur.sub;
                    holding  = 1'b1;
                end else begin
                    in_valid = 1'b0;
                    a        = W'($urandom);
                    b        = W'($urandom);
                    ci       = 1'($urandom_range(0, 1));
                    sub      = 1'($urandom_range(0, 1));
                end
            end
        end
        #2;
        if (rst) begin
            if (do_rst) begin
                exp_q.delete();
                do_rst   = 1'b0;
                post_rst = 1'b1;
            end
        end else if (in_valid && in_ready) begin
            e.r = model(stim_q.pop_front());
            e.t = $time;
            exp_q.push_back(e);
            holding = 1'b0;
        end
        cyc++;
    end

    // Monitor: compares whatever the DUT presents against the scoreboard
    always begin
        res_t held;
        res_t cur;
        exp_t e;
        bit   stalled;
        @(negedge clk);
        #2;
        cur = {sum, co, ovf, zero};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (post_rst) begin
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_sum", 64'(sum), 64'd0);
                chk("rst_co_ovf_zero", 64'({co, ovf, zero}), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                post_rst = 1'b0;
            end
            chk("in_ready", 64'(in_ready), 64'((exp_q.size() < 3) || out_ready));
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'(cur), 64'(held));
            end
            if (exp_q.size() == 0) begin
                chk("out_valid_idle", 64'(out_valid), 64'd0);
            end else begin
                chk("out_valid_latency", 64'(out_valid), 64'(($time + 1) >= (exp_q[0].t + 30)));
                if (out_valid && out_ready) begin
                    e = exp_q.pop_front();
                    chk("result", 64'(cur), 64'(e.r));
                end
            end
            stalled = out_valid && !out_ready;
            held    = cur;
        end
    end

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= max_cyc), 64'd0);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        repeat (4) @(negedge clk);

        // Directed arithmetic cases
        rdy_mode = 0;
        idle_pct = 0;
        push(16'h1234, 16'h4321, 1'b0, 1'b0);
        push(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        push(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        push(16'h0005, 16'h0007, 1'b0, 1'b1);
        push(16'h0005, 16'h0007, 1'b1, 1'b1);
        push(16'h1234, 16'h1234, 1'b0, 1'b1);
        push(16'h8000, 16'h0001, 1'b0, 1'b1);
        push(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drain(200);

        // Backpressure: continuous beats, consumer stalls for cycles 4..8
        @(negedge clk);
        cyc      = 0;
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) push(W'(i), 16'h0001, 1'b0, 1'b0);
        drain(200);

        // Reset with two beats in flight
        rdy_mode = 3;
        push(16'h0101, 16'h0202, 1'b0, 1'b0);
        push(16'h0303, 16'h0404, 1'b0, 1'b0);
        n = 0;
        while ((stim_q.size() > 0 || holding) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("inflight_accept_timeout", 64'(n >= 50), 64'd0);
        do_rst = 1'b1;
        n = 0;
        while (do_rst && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_timeout", 64'(n >= 20), 64'd0);
        rdy_mode = 0;
        repeat (10) @(negedge clk);

        // Random traffic with idle gaps and random backpressure
        rdy_mode = 1;
        idle_pct = 25;
        repeat (300) begin
            case ($urandom_range(0, 7))
                0:       ra = 16'hFFFF;
                1:       ra = 16'h7FFF;
                2:       ra = 16'h8000;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = ra;
                2:       rb = 16'h8000;
                default: rb = W'($urandom);
            endcase
            push(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain(5000);
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
